// File: rtl/alu4_pkg.sv
// alu4_pkg: shared ALU op encoding, result-entry layout and data width.
package alu4_pkg;
  localparam int ALU_W = 4;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;
  typedef struct packed {
    logic [1:0]       sel;
    logic [ALU_W-1:0] result;
    logic             carry;
    logic             zero;
  } alu4_entry_t;
endpackage

// File: rtl/alu4_rs_fifo.sv
// alu4_rs_fifo: DEPTH-entry first-word-fall-through FIFO of alu4_entry_t.
module alu4_rs_fifo import alu4_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  alu4_entry_t                  din,
  output alu4_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  alu4_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/alu4_result_stage.sv
// alu4_result_stage: buffers ALU results with masked carry and zero flag.
// Define ALU4_RS_STATS_EN to add the saturating carry_events counter.
module alu4_result_stage import alu4_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_W-1:0]           in_result,
  input  logic                       in_carry,
  input  logic [1:0]                 in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ALU_W-1:0]           out_result,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic [1:0]                 out_sel,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ALU4_RS_STATS_EN
  ,
  output logic [CNT_W-1:0]           carry_events
`endif
);
  alu4_entry_t din, head;
  logic push, pop, full, empty;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Carry is only meaningful for arithmetic ops.
  always_comb begin
    din.sel    = in_sel;
    din.result = in_result;
    din.carry  = (alu_op_e'(in_sel) inside {ALU_ADD, ALU_SUB}) ? in_carry : 1'b0;
    din.zero   = in_result == '0;
  end
  alu4_rs_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
    .head(head), .count(count), .full(full), .empty(empty)
  );
  assign out_result = head.result;
  assign out_carry  = head.carry;
  assign out_zero   = head.zero;
  assign out_sel    = head.sel;
`ifdef ALU4_RS_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) carry_events <= '0;
    else if (push && din.carry && carry_events != '1) carry_events <= carry_events + CNT_W'(1);
`endif
endmodule

// File: tb/tb_alu4_result_stage.sv
// tb_alu4_result_stage: directed and random checks against a queue model.
module tb_alu4_result_stage;
  import alu4_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, in_carry = 0, out_ready = 0;
  logic [3:0] in_result = '0;
  logic [1:0] in_sel = '0;
  logic in_ready, out_valid, out_carry, out_zero;
  logic [3:0] out_result;
  logic [1:0] out_sel;
  logic [2:0] count;
`ifdef ALU4_RS_STATS_EN
  logic [CNT_W-1:0] carry_events;
`endif
  int tests = 0, fails = 0;
  int ev = 0;
  alu4_entry_t q[$];

  alu4_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_sel(out_sel), .count(count)
`ifdef ALU4_RS_STATS_EN
    , .carry_events(carry_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic alu4_entry_t mk(logic [1:0] s, logic [3:0] r, logic c);
    alu4_entry_t e;
    e.sel = s;
    e.result = r;
    e.carry = (s == 2'b00 || s == 2'b01) ? c : 1'b0;
    e.zero = (r == 4'd0);
    return e;
  endfunction

  // Advance one clock; the model applies the handshake as seen before the edge.
  task automatic step();
    bit p = in_valid && q.size() != DEPTH;
    bit o = out_ready && q.size() != 0;
    alu4_entry_t e = mk(in_sel, in_result, in_carry);
    @(posedge clk); #1;
    if (o) void'(q.pop_front());
    if (p) begin
      q.push_back(e);
      if (e.carry && ev < (1 << CNT_W) - 1) ev++;
    end
  endtask

  task automatic drive(logic v, logic [1:0] s, logic [3:0] r, logic c, logic rdy);
    in_valid = v; in_sel = s; in_result = r; in_carry = c; out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    q.delete();
    ev = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, in_ready, count, out_result, out_carry, out_zero, out_sel} !== {1'b0, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL reset: got v=%b rdy=%b cnt=%0d res=%h c=%b z=%b sel=%0d", out_valid, in_ready, count, out_result, out_carry, out_zero, out_sel);
    end
`ifdef ALU4_RS_STATS_EN
    tests++;
    if (carry_events !== '0) begin fails++; $display("FAIL reset_events: got %0d want 0", carry_events); end
`endif
  endtask

  task automatic test_single();
    drive(1, 2'b00, 4'hF, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    tests++;
    if ({out_valid, out_result, out_carry, out_zero, count} !== {1'b1, 4'hF, 1'b1, 1'b0, 3'd1}) begin
      fails++;
      $display("FAIL single: got v=%b res=%h c=%b z=%b cnt=%0d want v=1 res=f c=1 z=0 cnt=1", out_valid, out_result, out_carry, out_zero, count);
    end
  endtask

  task automatic test_logic_mask();
    drive(1, 2'b10, 4'h0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0);
    tests++;
    if ({out_valid, out_sel, out_carry, out_zero, count} !== {1'b1, 2'b10, 1'b0, 1'b1, 3'd1}) begin
      fails++;
      $display("FAIL logic_mask: got v=%b sel=%0d c=%b z=%b cnt=%0d want v=1 sel=2 c=0 z=1 cnt=1", out_valid, out_sel, out_carry, out_zero, count);
    end
`ifdef ALU4_RS_STATS_EN
    tests++;
    if (carry_events !== CNT_W'(ev)) begin fails++; $display("FAIL mask_events: got %0d want %0d", carry_events, ev); end
`endif
    drive(1, 2'b11, 4'h6, 1, 1);
    step();
    drive(0, 0, 0, 0, 0);
    tests++;
    if ({out_sel, out_result, out_carry, out_zero} !== {2'b11, 4'h6, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL or_mask: got sel=%0d res=%h c=%b z=%b want sel=3 res=6 c=0 z=0", out_sel, out_result, out_carry, out_zero);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 2'($urandom), 4'($urandom), 1'($urandom), 0);
      step();
    end
    drive(1, 2'b01, 4'h9, 1, 0);
    step();
    tests++;
    if ({count, in_ready, out_valid} !== {3'd4, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL full: got cnt=%0d rdy=%b v=%b want cnt=4 rdy=0 v=1", count, in_ready, out_valid);
    end
    drive(1, 2'b01, 4'h9, 1, 1);
    step();
    tests++;
    if (count !== 3'd3) begin fails++; $display("FAIL full_no_bypass: got cnt=%0d want 3", count); end
    drive(0, 0, 0, 0, 1);
    while (q.size() != 0) begin
      tests++;
      if ({out_valid, out_sel, out_result, out_carry, out_zero} !== {1'b1, q[0]}) begin
        fails++;
        $display("FAIL drain: got v=%b sel=%0d res=%h c=%b z=%b want sel=%0d res=%h c=%b z=%b", out_valid, out_sel, out_result, out_carry, out_zero, q[0].sel, q[0].result, q[0].carry, q[0].zero);
      end
      step();
    end
    tests++;
    if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL drained: got v=%b cnt=%0d rdy=%b", out_valid, count, in_ready);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 2'($urandom), 4'($urandom), 1'($urandom), 0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 2'($urandom), 4'($urandom), 1'($urandom), 1);
      step();
      tests++;
      if ({count, out_valid, out_sel, out_result, out_carry, out_zero} !== {3'd2, 1'b1, q[0]}) begin
        fails++;
        $display("FAIL stream[%0d]: got cnt=%0d sel=%0d res=%h c=%b z=%b want cnt=2 sel=%0d res=%h c=%b z=%b", i, count, out_sel, out_result, out_carry, out_zero, q[0].sel, q[0].result, q[0].carry, q[0].zero);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_hold_reset();
    alu4_entry_t h;
    do_reset();
    drive(1, 2'b01, 4'h5, 1, 0);
    step();
    drive(1, 2'b00, 4'h0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    h = mk(2'b01, 4'h5, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({out_valid, out_sel, out_result, out_carry, out_zero} !== {1'b1, h}) begin
        fails++;
        $display("FAIL hold[%0d]: got v=%b sel=%0d res=%h c=%b z=%b want v=1 sel=1 res=5 c=1 z=0", i, out_valid, out_sel, out_result, out_carry, out_zero);
      end
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if ({out_valid, count, out_result, out_sel} !== {1'b0, 3'd0, 4'd0, 2'd0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b cnt=%0d res=%h sel=%0d want 0 0 0 0", out_valid, count, out_result, out_sel);
    end
    q.delete();
    ev = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL post_reset: got rdy=%b v=%b cnt=%0d want 1 0 0", in_ready, out_valid, count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 2'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), 1'($urandom));
      step();
      tests++;
      if ({count, out_valid, in_ready} !== {3'(q.size()), q.size() != 0, q.size() != DEPTH}) begin
        fails++;
        $display("FAIL rand_state[%0d]: got cnt=%0d v=%b rdy=%b want cnt=%0d", i, count, out_valid, in_ready, q.size());
      end
      if (q.size() != 0) begin
        tests++;
        if ({out_sel, out_result, out_carry, out_zero} !== q[0]) begin
          fails++;
          $display("FAIL rand_head[%0d]: got sel=%0d res=%h c=%b z=%b want sel=%0d res=%h c=%b z=%b", i, out_sel, out_result, out_carry, out_zero, q[0].sel, q[0].result, q[0].carry, q[0].zero);
        end
      end
`ifdef ALU4_RS_STATS_EN
      tests++;
      if (carry_events !== CNT_W'(ev)) begin fails++; $display("FAIL rand_events[%0d]: got %0d want %0d", i, carry_events, ev); end
`endif
    end
    drive(0, 0, 0, 0, 0);
  endtask

`ifdef ALU4_RS_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b00, 4'($urandom), 1, 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    tests++;
    if (carry_events !== 2'd3) begin fails++; $display("FAIL stats_sat: got %0d want 3", carry_events); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_logic_mask();
    test_full();
    test_back_to_back();
    test_hold_reset();
    test_random();
`ifdef ALU4_RS_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
